// File: rtl/store_image_if.sv
// rtl/store_image_if.sv - buffer-read and block-write bundle for store_image
interface store_image_if #(
  parameter int MEM_ADDR_SIZE  = 20,
  parameter int BLOCK_SIZE     = 150,
  parameter int DATA_SIZE      = 16,
  parameter int PIX_ADDR_WIDTH = 12
);
  // local pixel buffer read port
  logic                      rd_en;
  logic [PIX_ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_SIZE-1:0]      rd_data;
  // memory controller block-write port
  logic                      mem_wr;
  logic                      mem_ack;
  logic [MEM_ADDR_SIZE-1:0]  address;
  logic [DATA_SIZE-1:0]      block [0:BLOCK_SIZE-1];

  modport master (
    output rd_en, rd_addr, mem_wr, address, block,
    input  rd_data, mem_ack
  );

  modport slave (
    input  rd_en, rd_addr, mem_wr, address, block,
    output rd_data, mem_ack
  );
endinterface

// File: rtl/store_image.sv
// rtl/store_image.sv - drains the local pixel buffer to memory in fixed-size blocks
module store_image #(
  parameter int MEM_ADDR_SIZE  = 20,
  parameter int BLOCK_SIZE     = 150,
  parameter int DATA_SIZE      = 16,
  parameter int IMG_SIZE_WIDTH = 6,
  parameter int PIX_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [IMG_SIZE_WIDTH-1:0] i_img_size,
  input  logic [MEM_ADDR_SIZE-1:0]  i_initial_addr,
  store_image_if.master             bus,
  output logic                      o_busy,
  output logic                      o_done
);
  localparam int T_W = 2 * IMG_SIZE_WIDTH;
  localparam int K_W = $clog2(BLOCK_SIZE + 1);
  localparam logic [K_W-1:0] K_LAST       = K_W'(BLOCK_SIZE);
  localparam logic [K_W-1:0] K_LAST_ISSUE = K_W'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_FIN} state_t;

  state_t                    r_state;
  logic [T_W-1:0]            r_total;     // T = N*N, latched on start
  logic [T_W-1:0]            r_pix;       // next buffer word to read
  logic [K_W-1:0]            r_k;         // cycle index inside FETCH
  logic                      r_rd_en;
  logic                      r_rd_pend;   // a read was issued last cycle
  logic [PIX_ADDR_WIDTH-1:0] r_rd_addr;
  logic                      r_mem_wr;
  logic [MEM_ADDR_SIZE-1:0]  r_addr;
  logic [DATA_SIZE-1:0]      r_block [0:BLOCK_SIZE-1];
  logic                      r_busy;
  logic                      r_done;

  logic [T_W-1:0]            w_total_new;
  logic                      w_issue_next;

  assign w_total_new  = T_W'(i_img_size) * T_W'(i_img_size);
  // The issue slot for cycle k+1 is decided during cycle k so rd_en is registered.
  assign w_issue_next = (r_k < K_LAST_ISSUE) && (r_pix < r_total);

  // Sequencer: latch the job, stream buffer reads into block slots, hand each block to memory
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_total   <= '0;
      r_pix     <= '0;
      r_k       <= '0;
      r_rd_en   <= 1'b0;
      r_rd_pend <= 1'b0;
      r_rd_addr <= '0;
      r_mem_wr  <= 1'b0;
      r_addr    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      for (int i = 0; i < BLOCK_SIZE; i++) r_block[i] <= '0;
    end else begin
      r_rd_pend <= r_rd_en;
      r_rd_en   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_total <= w_total_new;
            r_addr  <= i_initial_addr;
            r_k     <= '0;
            r_busy  <= 1'b1;
            if (w_total_new == '0) begin
              r_pix   <= '0;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              // word 0 is issued in the first FETCH cycle
              r_pix     <= T_W'(1);
              r_rd_en   <= 1'b1;
              r_rd_addr <= '0;
              r_state   <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          // slot k-1 takes the data requested in the previous cycle, or zero past the image end
          if (r_k != '0) r_block[int'(r_k) - 1] <= r_rd_pend ? bus.rd_data : '0;
          if (r_k == K_LAST) begin
            r_mem_wr <= 1'b1;
            r_state  <= S_WRITE;
          end else begin
            r_k <= r_k + 1'b1;
            if (w_issue_next) begin
              r_rd_en   <= 1'b1;
              r_rd_addr <= PIX_ADDR_WIDTH'(r_pix);
              r_pix     <= r_pix + 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (bus.mem_ack) begin
            r_mem_wr <= 1'b0;
            r_addr   <= r_addr + MEM_ADDR_SIZE'(BLOCK_SIZE);
            // every word has been read once the counter reaches T, so this was the last block
            if (r_pix >= r_total) begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_k       <= '0;
              r_rd_en   <= 1'b1;
              r_rd_addr <= PIX_ADDR_WIDTH'(r_pix);
              r_pix     <= r_pix + 1'b1;
              r_state   <= S_FETCH;
            end
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_en   = r_rd_en;
  assign bus.rd_addr = r_rd_addr;
  assign bus.mem_wr  = r_mem_wr;
  assign bus.address = r_addr;
  assign bus.block   = r_block;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
endmodule
